// File: rtl/debounce_keys_multi.sv
// ---------------------------------------------------------------------------
// debounce_keys_multi
//
// Purpose:
//   Debounces N independent push-button channels and produces key events.
//   Each channel passes the raw asynchronous key through a 2-flop
//   synchroniser and normalises its polarity so that 1 means pressed. It
//   then filters the result to a stable level. On top of that level it
//   generates one-cycle press and release pulses, a long-press pulse and
//   optional auto-repeat pulses.
//
// Ports:
//   clk           in   1       system clock
//   rst_n         in   1       asynchronous active-low reset
//   key           in   N_KEYS  raw asynchronous key inputs, bit i = channel i
//   key_level     out  N_KEYS  debounced level, 1 = pressed
//   press_pulse   out  N_KEYS  1-cycle pulse on debounced press
//   release_pulse out  N_KEYS  1-cycle pulse on debounced release
//   long_pulse    out  N_KEYS  1-cycle pulse once held LONG_CYC cycles
//   repeat_pulse  out  N_KEYS  1-cycle pulse every REPEAT_CYC cycles after long
//   any_press     out  1       OR of press_pulse
// ---------------------------------------------------------------------------
module debounce_keys_multi #(
    parameter int N_KEYS       = 4,
    parameter int DEBOUNCE_CYC = 1500000,
    parameter int ACTIVE_LOW   = 0,
    parameter int LONG_CYC     = 100000000,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_CYC   = 20000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic [N_KEYS-1:0] repeat_pulse,
    output logic              any_press
);

    localparam int FILT_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [FILT_W-1:0] FILT_LAST   = FILT_W'(DEBOUNCE_CYC - 1);
    localparam logic [FILT_W-1:0] FILT_ONE    = FILT_W'(1);
    localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

    // Raw value a released key presents; the synchroniser resets to it so
    // that leaving reset never looks like a key edge.
    localparam logic RAW_RELEASED = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        HOLD_IDLE,
        HOLD_HELD,
        HOLD_REPEAT,
        HOLD_PARKED
    } hold_state_t;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        logic              sync1_q, sync1_d;
        logic              sync2_q, sync2_d;
        logic              s;
        logic              level_q, level_d;
        logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
        logic              press_q, press_d;
        logic              release_q, release_d;
        logic              long_q, long_d;
        logic              repeat_q, repeat_d;
        hold_state_t       state_q, state_d;
        logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

        // Synchroniser chain; s is the polarity-normalised sample.
        always_comb begin
            sync1_d = key[i];
            sync2_d = sync1_q;
            s       = sync2_q ^ RAW_RELEASED;
        end

        // Level filter: a new level is accepted only after it has been seen
        // for DEBOUNCE_CYC consecutive cycles. Seeing the current level
        // again throws the partial count away.
        always_comb begin
            level_d    = level_q;
            filt_cnt_d = filt_cnt_q;
            press_d    = 1'b0;
            release_d  = 1'b0;
            if (s == level_q) begin
                filt_cnt_d = '0;
            end else if (filt_cnt_q == FILT_LAST) begin
                level_d    = s;
                filt_cnt_d = '0;
                press_d    = s;
                release_d  = ~s;
            end else begin
                filt_cnt_d = filt_cnt_q + FILT_ONE;
            end
        end

        // Hold-time FSM. It uses the filter's press/release decisions of
        // this same cycle, so a release aborts any count on the very edge
        // where key_level drops. A release therefore beats a long or repeat
        // pulse that would otherwise fall on the same edge.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            long_d     = 1'b0;
            repeat_d   = 1'b0;
            if (release_d) begin
                state_d    = HOLD_IDLE;
                hold_cnt_d = '0;
            end else if (press_d) begin
                state_d    = HOLD_HELD;
                hold_cnt_d = '0;
            end else begin
                case (state_q)
                    HOLD_IDLE: begin
                        hold_cnt_d = '0;
                    end
                    HOLD_HELD: begin
                        if (hold_cnt_q == LONG_LAST) begin
                            long_d     = 1'b1;
                            hold_cnt_d = '0;
                            state_d    = (REPEAT_EN != 0) ? HOLD_REPEAT : HOLD_PARKED;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_ONE;
                        end
                    end
                    HOLD_REPEAT: begin
                        if (hold_cnt_q == REPEAT_LAST) begin
                            repeat_d   = 1'b1;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_ONE;
                        end
                    end
                    HOLD_PARKED: begin
                        hold_cnt_d = '0;
                    end
                    default: begin
                        state_d    = HOLD_IDLE;
                        hold_cnt_d = '0;
                    end
                endcase
            end
        end

        // All per-channel state. Reset drops every count and pulse at once.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q    <= RAW_RELEASED;
                sync2_q    <= RAW_RELEASED;
                level_q    <= 1'b0;
                filt_cnt_q <= '0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                long_q     <= 1'b0;
                repeat_q   <= 1'b0;
                state_q    <= HOLD_IDLE;
                hold_cnt_q <= '0;
            end else begin
                sync1_q    <= sync1_d;
                sync2_q    <= sync2_d;
                level_q    <= level_d;
                filt_cnt_q <= filt_cnt_d;
                press_q    <= press_d;
                release_q  <= release_d;
                long_q     <= long_d;
                repeat_q   <= repeat_d;
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
            end
        end

        assign key_level[i]     = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign long_pulse[i]    = long_q;
        assign repeat_pulse[i]  = repeat_q;
    end

    assign any_press = |press_pulse;

endmodule
